param_sync_fifo: RTL and testbench

Parametrised single-clock FIFO: next generation of the team's 8×4 synchronous FIFO. Generalised in width and depth, with a selectable read mode (registered or first-word-fall-through). Adds full/empty, programmable almost-full/almost-empty, occupancy count, and overflow/underflow error pulses. Sits between any producer/consumer pair in one clock domain and is the standard buffering primitive for new blocks.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/fifo_mem.sv | 26 ++
 rtl/param_sync_fifo.sv | 130 +++++++++++++
 tb/tb_param_sync_fifo.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO family.
package fifo_pkg;

  localparam bit FIFO_MODE_REG      = 1'b0;
  localparam bit FIFO_MODE_FWFT     = 1'b1;
  localparam int FIFO_AFULL_MARGIN  = 2;
  localparam int FIFO_AEMPTY_TH_DEF = 2;

  function automatic int fifo_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) begin
        r = r + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with registered or first-word-fall-through read, occupancy
// count, programmable almost-full/almost-empty and overflow/underflow pulses.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int  WIDTH     = 8,
  parameter int  DEPTH     = 16,
  localparam int AW        = fifo_clog2(DEPTH),
  parameter int  AFULL_TH  = DEPTH - FIFO_AFULL_MARGIN,
  parameter int  AEMPTY_TH = FIFO_AEMPTY_TH_DEF,
  parameter bit  FWFT      = FIFO_MODE_REG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] data,
  input  logic             re,
  output logic [WIDTH-1:0] read_data,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [AW-1:0] C_PTR_LAST  = AW'(DEPTH - 1);
  localparam logic [AW:0]   C_DEPTH     = (AW+1)'(DEPTH);
  localparam logic [AW:0]   C_ONE       = (AW+1)'(1);
  localparam logic [AW:0]   C_AFULL_TH  = (AW+1)'(AFULL_TH);
  localparam logic [AW:0]   C_AEMPTY_TH = (AW+1)'(AEMPTY_TH);

  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_count;
  logic             r_overflow;
  logic             r_underflow;
  logic [AW:0]      w_count_nxt;
  logic             w_full;
  logic             w_empty;
  logic             w_rd_acc;
  logic             w_wr_acc;
  logic [WIDTH-1:0] w_mem_rd;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == C_PTR_LAST) begin
      return {AW{1'b0}};
    end else begin
      return p + AW'(1);
    end
  endfunction

  assign w_full   = (r_count == C_DEPTH);
  assign w_empty  = (r_count == {(AW+1){1'b0}});
  assign w_rd_acc = re && !w_empty;
  assign w_wr_acc = we && (!w_full || w_rd_acc);

  // Occupancy next-state: simultaneous accepted read and write cancel out.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + C_ONE;
      2'b01:   w_count_nxt = r_count - C_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers, occupancy and error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp        <= {AW{1'b0}};
      r_rp        <= {AW{1'b0}};
      r_count     <= {(AW+1){1'b0}};
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wp <= ptr_inc(r_wp);
      end
      if (w_rd_acc) begin
        r_rp <= ptr_inc(r_rp);
      end
      r_count     <= w_count_nxt;
      r_overflow  <= we && !w_wr_acc;
      r_underflow <= re && !w_rd_acc;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wp),
    .i_wdata (data),
    .i_raddr (r_rp),
    .o_rdata (w_mem_rd)
  );

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    // Head is forced to zero while empty so the output never shows stale or unwritten storage.
    assign read_data = w_empty ? {WIDTH{1'b0}} : w_mem_rd;
  end else begin : g_reg
    logic [WIDTH-1:0] r_rd_data;

    // Registered read port: updates only on an accepted read.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_rd_data <= {WIDTH{1'b0}};
      end else if (w_rd_acc) begin
        r_rd_data <= w_mem_rd;
      end
    end

    assign read_data = r_rd_data;
  end

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= C_AFULL_TH);
  assign almost_empty = (r_count <= C_AEMPTY_TH);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench: table-driven vectors for the 16-deep registered FIFO, plus
// hand sequences for a 5-deep wrap test and an FWFT/async-reset test.
module tb_param_sync_fifo;

  typedef struct {
    int we;
    int re;
    int data;
    int rd;
    int cnt;
    int ovf;
    int udf;
  } vec_t;

  logic clk;
  int   n_checks;
  int   n_fail;

  // Instance A: WIDTH=8, DEPTH=16, registered read
  logic       a_rst, a_we, a_re;
  logic [7:0] a_data, a_rd;
  logic       a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
  logic [4:0] a_cnt;

  // Instance B: DEPTH=5, registered read
  logic       b_rst, b_we, b_re;
  logic [7:0] b_data, b_rd;
  logic       b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
  logic [3:0] b_cnt;

  // Instance C: DEPTH=16, first-word-fall-through
  logic       c_rst, c_we, c_re;
  logic [7:0] c_data, c_rd;
  logic       c_full, c_empty, c_af, c_ae, c_ovf, c_udf;
  logic [4:0] c_cnt;

  param_sync_fifo #(.WIDTH(8), .DEPTH(16), .FWFT(1'b0)) u_a (
    .clk(clk), .rst(a_rst), .we(a_we), .data(a_data), .re(a_re),
    .read_data(a_rd), .full(a_full), .empty(a_empty), .almost_full(a_af),
    .almost_empty(a_ae), .count(a_cnt), .overflow(a_ovf), .underflow(a_udf)
  );

  param_sync_fifo #(.WIDTH(8), .DEPTH(5), .FWFT(1'b0)) u_b (
    .clk(clk), .rst(b_rst), .we(b_we), .data(b_data), .re(b_re),
    .read_data(b_rd), .full(b_full), .empty(b_empty), .almost_full(b_af),
    .almost_empty(b_ae), .count(b_cnt), .overflow(b_ovf), .underflow(b_udf)
  );

  param_sync_fifo #(.WIDTH(8), .DEPTH(16), .FWFT(1'b1)) u_c (
    .clk(clk), .rst(c_rst), .we(c_we), .data(c_data), .re(c_re),
    .read_data(c_rd), .full(c_full), .empty(c_empty), .almost_full(c_af),
    .almost_empty(c_ae), .count(c_cnt), .overflow(c_ovf), .underflow(c_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int we, input int re, input int data,
                              input int rd, input int cnt, input int ovf, input int udf);
    vec_t v;
    v.we = we; v.re = re; v.data = data; v.rd = rd;
    v.cnt = cnt; v.ovf = ovf; v.udf = udf;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    a_rst = 1'b1; a_we = 1'b0; a_re = 1'b0; a_data = 8'h00;
    b_rst = 1'b1; b_we = 1'b0; b_re = 1'b0; b_data = 8'h00;
    c_rst = 1'b1; c_we = 1'b0; c_re = 1'b0; c_data = 8'h00;

    // ---- vector table for instance A ----
    for (int k = 1; k <= 16; k++) vecs.push_back(mk(1, 0, k, 0, k, 0, 0));
    vecs.push_back(mk(1, 0, 8'hAA, 0, 16, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 16, 0, 0));
    for (int k = 1; k <= 16; k++) vecs.push_back(mk(0, 1, 0, k, 16 - k, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16, 0, 0, 1));
    vecs.push_back(mk(1, 1, 8'h55, 16, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 16, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h55, 0, 0, 0));
    for (int k = 1; k <= 16; k++) vecs.push_back(mk(1, 0, 8'h20 + k, 8'h55, k, 0, 0));
    for (int j = 0; j < 10; j++) vecs.push_back(mk(1, 1, 8'h40 + j, 8'h21 + j, 16, 0, 0));
    for (int k = 0; k < 16; k++)
      vecs.push_back(mk(0, 1, 0, (k < 6) ? (8'h2B + k) : (8'h40 + k - 6), 15 - k, 0, 0));

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    chk("A.reset.count", 32'(a_cnt), 32'd0);
    chk("A.reset.empty", 32'(a_empty), 32'd1);
    chk("A.reset.full", 32'(a_full), 32'd0);
    chk("A.reset.afull", 32'(a_af), 32'd0);
    chk("A.reset.aempty", 32'(a_ae), 32'd1);
    chk("A.reset.rd", 32'(a_rd), 32'd0);
    chk("A.reset.ovf", 32'(a_ovf), 32'd0);
    chk("A.reset.udf", 32'(a_udf), 32'd0);
    chk("C.reset.rd", 32'(c_rd), 32'd0);
    @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

    // ---- apply table to A ----
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      a_we   = (vecs[i].we != 0);
      a_re   = (vecs[i].re != 0);
      a_data = 8'(vecs[i].data);
      @(posedge clk);
      #1;
      chk($sformatf("A[%0d].rd", i), 32'(a_rd), 32'(vecs[i].rd));
      chk($sformatf("A[%0d].count", i), 32'(a_cnt), 32'(vecs[i].cnt));
      chk($sformatf("A[%0d].full", i), 32'(a_full), 32'(vecs[i].cnt == 16));
      chk($sformatf("A[%0d].empty", i), 32'(a_empty), 32'(vecs[i].cnt == 0));
      chk($sformatf("A[%0d].afull", i), 32'(a_af), 32'(vecs[i].cnt >= 14));
      chk($sformatf("A[%0d].aempty", i), 32'(a_ae), 32'(vecs[i].cnt <= 2));
      chk($sformatf("A[%0d].ovf", i), 32'(a_ovf), 32'(vecs[i].ovf));
      chk($sformatf("A[%0d].udf", i), 32'(a_udf), 32'(vecs[i].udf));
    end
    @(negedge clk);
    a_we = 1'b0; a_re = 1'b0;

    // ---- B: DEPTH=5, 3 writes / 3 reads x4, pointers wrap ----
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        b_we = 1'b1; b_re = 1'b0; b_data = 8'(16 * r + i + 1);
        @(posedge clk);
        #1;
        chk($sformatf("B.r%0d.w%0d.count", r, i), 32'(b_cnt), 32'(i + 1));
      end
      chk($sformatf("B.r%0d.afull", r), 32'(b_af), 32'd1);
      chk($sformatf("B.r%0d.full", r), 32'(b_full), 32'd0);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        b_we = 1'b0; b_re = 1'b1;
        @(posedge clk);
        #1;
        chk($sformatf("B.r%0d.r%0d.rd", r, i), 32'(b_rd), 32'(16 * r + i + 1));
        chk($sformatf("B.r%0d.r%0d.count", r, i), 32'(b_cnt), 32'(2 - i));
      end
      chk($sformatf("B.r%0d.empty", r), 32'(b_empty), 32'd1);
      chk($sformatf("B.r%0d.aempty", r), 32'(b_ae), 32'd1);
      chk($sformatf("B.r%0d.errs", r), 32'({b_ovf, b_udf}), 32'd0);
    end
    @(negedge clk);
    b_re = 1'b0;

    // ---- C: FWFT, then asynchronous reset mid-burst ----
    @(negedge clk);
    c_we = 1'b1; c_data = 8'h3C;
    @(posedge clk);
    #1;
    chk("C.fwft.rd", 32'(c_rd), 32'h3C);
    chk("C.fwft.count", 32'(c_cnt), 32'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      c_data = 8'(8'h3D + i);
      @(posedge clk);
      #1;
      chk($sformatf("C.burst%0d.rd", i), 32'(c_rd), 32'h3C);
    end
    @(negedge clk);
    c_data = 8'h3F; c_re = 1'b1;
    @(posedge clk);
    #1;
    chk("C.pop.rd", 32'(c_rd), 32'h3D);
    chk("C.pop.count", 32'(c_cnt), 32'd3);
    @(negedge clk);
    c_re = 1'b0; c_data = 8'h40;
    #2;
    c_rst = 1'b1;
    #1;
    chk("C.async_rst.count", 32'(c_cnt), 32'd0);
    chk("C.async_rst.empty", 32'(c_empty), 32'd1);
    chk("C.async_rst.rd", 32'(c_rd), 32'd0);
    chk("C.async_rst.flags", 32'({c_full, c_af, c_ae}), 32'b001);
    @(posedge clk);
    #1;
    chk("C.rst_cycle.count", 32'(c_cnt), 32'd0);
    chk("C.rst_cycle.errs", 32'({c_ovf, c_udf}), 32'd0);
    @(negedge clk);
    c_rst = 1'b0; c_data = 8'h77;
    @(posedge clk);
    #1;
    chk("C.after_rst.rd", 32'(c_rd), 32'h77);
    chk("C.after_rst.count", 32'(c_cnt), 32'd1);
    @(negedge clk);
    c_we = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
